// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU reset/clock-enable control logic.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_RESET_CYCLES    = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 8;

  // Width wide enough to hold the larger of two terminal counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a saturating debounce counter.
// press is high for the single cycle in which the counter is about to reach
// CYCLES, so the consumer registers the event on the edge the count lands.
module debounce_sync
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WIDTH  = cnt_width(CYCLES, CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [WIDTH-1:0] TARGET = WIDTH'(CYCLES);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [WIDTH-1:0] cnt;

  // Synchronize the raw button and count consecutive high cycles, saturating at CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != TARGET) begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  assign press = sync2 && (cnt == LAST);

endmodule

// File: rtl/cpu_reset_sequencer.sv
// Processor reset stretcher, button debouncer and run/step clock-enable control.
// Optional single-step support is built when CPU_SINGLE_STEP_EN is defined;
// otherwise btn_step is ignored and the core is frozen while halted.
module cpu_reset_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_reset,
  input  logic btn_step,
  input  logic run_mode,
  output logic cpu_reset,
  output logic cpu_clk_en,
  output logic ready
);

  localparam int unsigned      CNT_W     = cnt_width(RESET_CYCLES, DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             mode_s1;
  logic             run_mode_s;
  logic             reset_press;
  logic             step_press;

  debounce_sync #(
    .CYCLES(DEBOUNCE_CYCLES),
    .WIDTH (CNT_W)
  ) u_reset_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_reset),
    .press(reset_press)
  );

`ifdef CPU_SINGLE_STEP_EN
  debounce_sync #(
    .CYCLES(DEBOUNCE_CYCLES),
    .WIDTH (CNT_W)
  ) u_step_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_step),
    .press(step_press)
  );
`else
  logic unused_btn_step;
  assign unused_btn_step = btn_step;
  assign step_press      = 1'b0;
`endif

  // Two-flop synchronizer for the run/halt switch (no debounce needed for a level).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s1    <= 1'b0;
      run_mode_s <= 1'b0;
    end else begin
      mode_s1    <= run_mode;
      run_mode_s <= mode_s1;
    end
  end

  // Sequencer FSM; outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      cpu_clk_en <= 1'b0;
      ready      <= 1'b0;
    end else if (reset_press) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      cpu_clk_en <= 1'b0;
      ready      <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            cpu_reset  <= 1'b0;
            ready      <= 1'b1;
            cpu_clk_en <= run_mode_s;
            state      <= run_mode_s ? RUN : HALT;
          end else begin
            hold_cnt   <= hold_cnt + CNT_W'(1);
            cpu_reset  <= 1'b1;
            ready      <= 1'b0;
            cpu_clk_en <= 1'b0;
          end
        end
        RUN: begin
          cpu_reset <= 1'b0;
          ready     <= 1'b1;
          if (!run_mode_s) begin
            state      <= HALT;
            cpu_clk_en <= 1'b0;
          end else begin
            cpu_clk_en <= 1'b1;
          end
        end
        HALT: begin
          cpu_reset <= 1'b0;
          ready     <= 1'b1;
          if (run_mode_s) begin
            state      <= RUN;
            cpu_clk_en <= 1'b1;
          end else begin
            cpu_clk_en <= step_press;
          end
        end
        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          cpu_reset  <= 1'b1;
          cpu_clk_en <= 1'b0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule
